// File: rtl/stim_stream_driver.sv
// Buffered stimulus streamer: holds DEPTH items of NUM_OPS operands and plays
// them out over valid/ready, in one-shot or looping passes with graceful stop.
module stim_stream_driver #(
  parameter int OP_WIDTH = 8,
  parameter int NUM_OPS  = 2,
  parameter int DEPTH    = 100,
  parameter int AW       = $clog2(DEPTH),
  parameter int CNT_W    = 32
) (
  input  logic                         clk_i,
  input  logic                         reset_ni,
  input  logic                         wr_en_i,
  input  logic [AW-1:0]                wr_addr_i,
  input  logic [OP_WIDTH*NUM_OPS-1:0]  wr_data_i,
  input  logic [AW:0]                  count_i,
  input  logic                         loop_i,
  input  logic                         start_i,
  input  logic                         stop_i,
  output logic [OP_WIDTH*NUM_OPS-1:0]  ops_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [CNT_W-1:0]             sent_cnt_o,
  output logic                         wr_err_o
);

  localparam int IW = OP_WIDTH * NUM_OPS;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t          state_q;
  logic [AW-1:0]   idx_q;
  logic [AW:0]     cnt_q;
  logic            loop_q;
  logic            stop_pend_q;
  logic [IW-1:0]   mem [DEPTH];

  logic            start_ok;
  logic            addr_ok;
  logic            wr_ok;
  logic            hs;
  logic            last;
  logic            finish;
  logic [AW-1:0]   idx_nxt;

  assign start_ok = (state_q == S_IDLE) && start_i && (count_i != '0) && (count_i <= DEPTH_C);
  assign addr_ok  = {1'b0, wr_addr_i} < DEPTH_C;
  // A start on the same edge closes the write window, so that write is dropped too.
  assign wr_ok    = wr_en_i && (state_q == S_IDLE) && addr_ok && !start_ok;
  assign hs       = (state_q == S_RUN) && valid_o && ready_i;
  assign last     = {1'b0, idx_q} == (cnt_q - (AW+1)'(1));
  assign finish   = stop_pend_q || stop_i || (last && !loop_q);
  assign idx_nxt  = idx_q + AW'(1);

  // Buffer storage carries no reset; contents survive reset_ni.
  always_ff @(posedge clk_i) begin
    if (wr_ok) mem[wr_addr_i] <= wr_data_i;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      loop_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      ops_o       <= '0;
      valid_o     <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      sent_cnt_o  <= '0;
      wr_err_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (wr_en_i && !wr_ok) wr_err_o <= 1'b1;

      if (state_q == S_IDLE) begin
        if (start_ok) begin
          cnt_q       <= count_i;
          loop_q      <= loop_i;
          idx_q       <= '0;
          sent_cnt_o  <= '0;
          stop_pend_q <= 1'b0;
          ops_o       <= mem[0];
          valid_o     <= 1'b1;
          busy_o      <= 1'b1;
          state_q     <= S_RUN;
        end
      end else begin
        if (hs) begin
          sent_cnt_o <= sent_cnt_o + CNT_W'(1);
          if (finish) begin
            state_q     <= S_IDLE;
            valid_o     <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b1;
            stop_pend_q <= 1'b0;
          end else if (last) begin
            idx_q <= '0;
            ops_o <= mem[0];
          end else begin
            idx_q <= idx_nxt;
            ops_o <= mem[idx_nxt];
          end
        end else if (stop_i) begin
          stop_pend_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_stim_stream_driver.sv
// Directed bench for stim_stream_driver: load, stream, stall, loop/stop,
// dropped writes, start qualification and asynchronous abort.
module tb_stim_stream_driver;

  localparam int OP_WIDTH = 8;
  localparam int NUM_OPS  = 2;
  localparam int DEPTH    = 100;
  localparam int AW       = 7;
  localparam int CNT_W    = 32;
  localparam int IW       = OP_WIDTH * NUM_OPS;

  logic              clk_i = 1'b0;
  logic              reset_ni;
  logic              wr_en_i;
  logic [AW-1:0]     wr_addr_i;
  logic [IW-1:0]     wr_data_i;
  logic [AW:0]       count_i;
  logic              loop_i;
  logic              start_i;
  logic              stop_i;
  logic [IW-1:0]     ops_o;
  logic              valid_o;
  logic              ready_i;
  logic              busy_o;
  logic              done_o;
  logic [CNT_W-1:0]  sent_cnt_o;
  logic              wr_err_o;

  stim_stream_driver #(
    .OP_WIDTH(OP_WIDTH), .NUM_OPS(NUM_OPS), .DEPTH(DEPTH), .AW(AW), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .count_i(count_i), .loop_i(loop_i), .start_i(start_i), .stop_i(stop_i),
    .ops_o(ops_o), .valid_o(valid_o), .ready_i(ready_i),
    .busy_o(busy_o), .done_o(done_o), .sent_cnt_o(sent_cnt_o), .wr_err_o(wr_err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_pass = 0;
  logic [IW-1:0] got_q[$];
  int cycles;
  int done_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [IW-1:0] d);
    wr_en_i = 1'b1; wr_addr_i = a; wr_data_i = d;
    step();
    wr_en_i = 1'b0;
  endtask

  task automatic do_start(input int cnt, input logic lp);
    count_i = (AW+1)'(cnt); loop_i = lp; start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  function automatic logic [IW-1:0] big_item(input int i);
    logic [7:0] lo;
    lo = 8'(i);
    return {lo + 8'h80, lo};
  endfunction

  // Plays the sink side: ready follows a 4-cycle pattern; stop_i is raised once
  // stop_after handshakes have been seen. Collects accepted items in got_q.
  task automatic stream(input string tag, input logic [3:0] pat, input int stop_after,
                        input int max_cyc);
    logic          hs;
    logic          hv;
    logic [IW-1:0] held;
    got_q.delete();
    cycles   = 0;
    done_cnt = 0;
    for (int c = 0; c < max_cyc; c++) begin
      ready_i = pat[c % 4];
      stop_i  = (stop_after > 0) && (got_q.size() == stop_after);
      hs   = valid_o && ready_i;
      hv   = valid_o;
      held = ops_o;
      if (hs) got_q.push_back(ops_o);
      step();
      cycles++;
      if (hv && !hs) begin
        chk({tag, "_hold_valid"}, 64'(valid_o), 64'd1);
        chk({tag, "_hold_ops"}, 64'(ops_o), 64'(held));
      end
      if (done_o) begin
        done_cnt++;
        break;
      end
    end
    stop_i  = 1'b0;
    ready_i = 1'b1;
    chk({tag, "_done_seen"}, 64'(done_cnt), 64'd1);
    chk({tag, "_busy_after"}, 64'(busy_o), 64'd0);
    chk({tag, "_valid_after"}, 64'(valid_o), 64'd0);
    step();
    chk({tag, "_done_pulse"}, 64'(done_o), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_ni = 1'b0; wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
    count_i = '0; loop_i = 1'b0; start_i = 1'b0; stop_i = 1'b0; ready_i = 1'b0;
    #12;
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_ops", 64'(ops_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_sent", 64'(sent_cnt_o), 64'd0);
    chk("rst_wrerr", 64'(wr_err_o), 64'd0);
    step();
    reset_ni = 1'b1;
    step();

    // Test 1: one-shot, sink always ready
    wr(0, 16'h0201); wr(1, 16'h0403); wr(2, 16'h0605); wr(3, 16'h0807);
    chk("t1_wrerr", 64'(wr_err_o), 64'd0);
    ready_i = 1'b1;
    do_start(4, 1'b0);
    chk("t1_first_valid", 64'(valid_o), 64'd1);
    chk("t1_busy", 64'(busy_o), 64'd1);
    chk("t1_sent0", 64'(sent_cnt_o), 64'd0);
    stream("t1", 4'b1111, 0, 50);
    chk("t1_cycles", 64'(cycles), 64'd4);
    chk("t1_n", 64'(got_q.size()), 64'd4);
    if (got_q.size() == 4) begin
      chk("t1_i0", 64'(got_q[0]), 64'h0201);
      chk("t1_i1", 64'(got_q[1]), 64'h0403);
      chk("t1_i2", 64'(got_q[2]), 64'h0605);
      chk("t1_i3", 64'(got_q[3]), 64'h0807);
    end
    chk("t1_sent", 64'(sent_cnt_o), 64'd4);

    // Test 2: stalls with ready 1,0,0,1,...
    do_start(4, 1'b0);
    stream("t2", 4'b1001, 0, 50);
    chk("t2_n", 64'(got_q.size()), 64'd4);
    if (got_q.size() == 4) begin
      chk("t2_i0", 64'(got_q[0]), 64'h0201);
      chk("t2_i1", 64'(got_q[1]), 64'h0403);
      chk("t2_i2", 64'(got_q[2]), 64'h0605);
      chk("t2_i3", 64'(got_q[3]), 64'h0807);
    end
    chk("t2_sent", 64'(sent_cnt_o), 64'd4);

    // Test 3: loop of 3, stop after 7 handshakes
    do_start(3, 1'b1);
    stream("t3", 4'b1111, 7, 50);
    chk("t3_n", 64'(got_q.size()), 64'd8);
    if (got_q.size() == 8) begin
      chk("t3_i0", 64'(got_q[0]), 64'h0201);
      chk("t3_i1", 64'(got_q[1]), 64'h0403);
      chk("t3_i2", 64'(got_q[2]), 64'h0605);
      chk("t3_i3", 64'(got_q[3]), 64'h0201);
      chk("t3_i5", 64'(got_q[5]), 64'h0605);
      chk("t3_i6", 64'(got_q[6]), 64'h0201);
      chk("t3_i7", 64'(got_q[7]), 64'h0403);
    end
    chk("t3_sent", 64'(sent_cnt_o), 64'd8);

    // Test 4: dropped writes
    wr(7'(DEPTH), 16'hdead);
    chk("t4_err_oob", 64'(wr_err_o), 64'd1);
    #2 reset_ni = 1'b0;
    #1 chk("t4_err_clear", 64'(wr_err_o), 64'd0);
    step();
    reset_ni = 1'b1;
    step();
    ready_i = 1'b0;
    do_start(4, 1'b0);
    wr(0, 16'hffff);
    chk("t4_err_run", 64'(wr_err_o), 64'd1);
    chk("t4_valid_stall", 64'(valid_o), 64'd1);
    stream("t4", 4'b1111, 0, 50);
    chk("t4_n", 64'(got_q.size()), 64'd4);
    if (got_q.size() == 4) begin
      chk("t4_i0", 64'(got_q[0]), 64'h0201);
      chk("t4_i3", 64'(got_q[3]), 64'h0807);
    end
    chk("t4_err_sticky", 64'(wr_err_o), 64'd1);

    // Test 5: start qualification and full-depth stream
    do_start(0, 1'b0);
    chk("t5_cnt0_busy", 64'(busy_o), 64'd0);
    chk("t5_cnt0_valid", 64'(valid_o), 64'd0);
    do_start(DEPTH + 1, 1'b0);
    chk("t5_over_busy", 64'(busy_o), 64'd0);
    chk("t5_over_valid", 64'(valid_o), 64'd0);
    for (int i = 0; i < DEPTH; i++) wr(7'(i), big_item(i));
    do_start(DEPTH, 1'b0);
    stream("t5", 4'b1111, 0, 300);
    chk("t5_n", 64'(got_q.size()), 64'(DEPTH));
    for (int i = 0; i < got_q.size(); i++) chk($sformatf("t5_i%0d", i), 64'(got_q[i]), 64'(big_item(i)));
    chk("t5_sent", 64'(sent_cnt_o), 64'(DEPTH));

    // Test 6: asynchronous abort mid-stream
    ready_i = 1'b1;
    do_start(DEPTH, 1'b0);
    step(); step(); step();
    chk("t6_pre_valid", 64'(valid_o), 64'd1);
    #2 reset_ni = 1'b0;
    #1;
    chk("t6_valid", 64'(valid_o), 64'd0);
    chk("t6_busy", 64'(busy_o), 64'd0);
    chk("t6_ops", 64'(ops_o), 64'd0);
    chk("t6_sent", 64'(sent_cnt_o), 64'd0);
    chk("t6_done", 64'(done_o), 64'd0);
    step();
    reset_ni = 1'b1;
    step();
    chk("t6_done_post", 64'(done_o), 64'd0);
    chk("t6_busy_post", 64'(busy_o), 64'd0);
    do_start(2, 1'b0);
    stream("t6", 4'b1111, 0, 20);
    chk("t6_n", 64'(got_q.size()), 64'd2);
    if (got_q.size() == 2) begin
      chk("t6_i0", 64'(got_q[0]), 64'h8000);
      chk("t6_i1", 64'(got_q[1]), 64'h8101);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
